// File: rtl/v_counters_4_seq.sv
// Sequencing controller for a load-constant up counter.
// Parks the counter at LOAD_VAL, releases it for LIMIT load-to-terminal
// windows, and tracks every counter value against a shadow count.
module v_counters_4_seq #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] LOAD_VAL = 4'b1010,
  parameter logic [WIDTH-1:0] TERM_VAL = 4'b1111
) (
  input  logic             C,
  input  logic             R,
  input  logic             START,
  input  logic [3:0]       LIMIT,
  input  logic [WIDTH-1:0] Q,
  output logic             SLOAD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [3:0]       PERIODS
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       lim_q, lim_d;
  logic [3:0]       periods_q, periods_d;
  logic             err_q, err_d;
  logic [3:0]       periods_inc;

  assign periods_inc = periods_q + 4'd1;

  // Next-state logic: start acceptance, shadow-count tracking, window counting.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    lim_d     = lim_q;
    periods_d = periods_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        // A start is only honoured once the counter is parked at LOAD_VAL.
        if (START && (Q == LOAD_VAL)) begin
          state_d   = S_RUN;
          exp_d     = LOAD_VAL;
          lim_d     = LIMIT;
          periods_d = 4'd0;
          err_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (Q != exp_q) begin
          // Mismatch wins over every other transition; window count is frozen.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (Q != TERM_VAL) begin
          exp_d = exp_q + WIDTH'(1);
        end else begin
          // End of a window: counter reloads on this same edge.
          exp_d     = LOAD_VAL;
          periods_d = periods_inc;
          // Modulo-16 compare makes LIMIT=0 mean sixteen windows.
          if (periods_inc == lim_q) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= S_IDLE;
      exp_q     <= LOAD_VAL;
      lim_q     <= 4'd0;
      periods_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      lim_q     <= lim_d;
      periods_q <= periods_d;
      err_q     <= err_d;
    end
  end

  // Counter load request: held whenever the counter is not actively released,
  // and at the terminal value so each window restarts from LOAD_VAL.
  always_comb begin
    SLOAD = R || (state_q != S_RUN) || (Q == TERM_VAL);
  end

  assign BUSY    = (state_q == S_RUN);
  assign DONE    = (state_q == S_FIN);
  assign ERR     = err_q;
  assign PERIODS = periods_q;

endmodule

// File: doc/v_counters_4_seq.md
# v_counters_4_seq

Sequencing controller that sits directly upstream of the 4-bit load-constant up counter and drives its `SLOAD` input. It also consumes the counter's `Q` output. It parks the counter at its load constant, then releases it for a programmed number of load-to-terminal windows. Throughout each run it checks every counter value against an internal shadow count and reports completion or mismatch.

## Interface

Parameters:
- `WIDTH`, 4: width of counter value `Q`.
- `LOAD_VAL`, 4'b1010: constant the counter loads when `SLOAD` is high. Must match the counter.
- `TERM_VAL`, 4'b1111: last value of each window. `LOAD_VAL < TERM_VAL` is required.

Ports:
- `C`, input, 1: clock, rising edge. This is the only clock.
- `R`, input, 1: reset, synchronous, active-high.
- `START`, input, 1: request a run. Level-sampled at the rising edge of `C`.
- `LIMIT`, input, 4: number of windows per run. 0 means 16. Latched when `START` is accepted.
- `Q`, input, `WIDTH`: current counter value.
- `SLOAD`, output, 1: load request to the counter. Combinational from state, `Q` and `R`.
- `BUSY`, output, 1: high while state is RUN.
- `DONE`, output, 1: one-cycle pulse when a run completes.
- `ERR`, output, 1: sticky mismatch flag.
- `PERIODS`, output, 4: number of windows completed in the current or last run.

## Operation

- States:
  - IDLE: counter parked.
  - RUN: counter released.
  - FIN: one-cycle completion state.
- Registered state: `state`, `EXP` (WIDTH-bit shadow count), `LIM` (latched limit), `PERIODS`, `ERR`.
- `SLOAD` is high when `R`=1, or state is IDLE, or state is FIN, or (state is RUN and `Q`==`TERM_VAL`).
- IDLE:
  - `START`=1 and `Q`==`LOAD_VAL`: go to RUN. Set `EXP`=`LOAD_VAL`, `LIM`=`LIMIT`, `PERIODS`=0, `ERR`=0.
  - `START`=1 and `Q`!=`LOAD_VAL`: request ignored, because the counter is not yet parked.
- RUN, on each cycle:
  - `Q`!=`EXP`: set `ERR`=1 and go to IDLE. `PERIODS` is not updated. Error takes priority over every other transition.
  - `Q`==`EXP` and `Q`!=`TERM_VAL`: `EXP` <= `EXP`+1.
  - `Q`==`EXP`==`TERM_VAL`: `EXP` <= `LOAD_VAL` and `PERIODS` <= `PERIODS`+1 (modulo 16).
    - If `PERIODS`+1 equals `LIM` (modulo 16, so `LIM`=0 completes after 16 windows): go to FIN.
    - Otherwise: stay in RUN. The counter reloads `LOAD_VAL` on the same edge.
- FIN: `DONE`=1 and `SLOAD`=1. Go to IDLE on the next edge.
- `START` is ignored in RUN and FIN. No queuing.
- `ERR` holds until the next accepted `START`, or until `R`.
- Window length is `TERM_VAL`-`LOAD_VAL`+1 cycles; the defaults give 6 cycles.

## Timing

- Reset state, on the edge after `R`=1: state IDLE, `BUSY`=0, `DONE`=0, `ERR`=0, `PERIODS`=0, `EXP`=`LOAD_VAL`.
- `SLOAD`=1 in the same cycle `R` is high, so the counter holds `LOAD_VAL` from the first edge after reset.
- `R` asserted mid-run overrides all other inputs:
  - Next cycle is IDLE.
  - `DONE` is not pulsed and `ERR` is cleared.
  - The counter is reloaded on the same edge.
- Start latency: `START` is accepted at edge 0. `BUSY`=1 from cycle 0+, with `Q`=`LOAD_VAL` and `SLOAD`=0.
- Each window occupies 6 cycles with `Q`=10,11,12,13,14,15. `SLOAD`=1 only in the cycle where `Q`=15.
- A run with N windows: `BUSY` is high for 6N cycles, then `DONE` is high for one cycle, then IDLE.
  - A new `START` can be accepted at the first IDLE edge.
  - From `START` sampling to `DONE`: 6N+1 cycles.
- `PERIODS` increments at the edge that ends each window. It holds its value after FIN and after an error.
- A `Q` mismatch in cycle k gives `ERR`=1 and `BUSY`=0 in cycle k+1, with `SLOAD`=1 from cycle k+1.

## Test plan

- Reset: hold `R`=1 for 2 cycles with `Q`=3.
  - Required: `SLOAD`=1 in both cycles.
  - Required after release: `BUSY`=0, `DONE`=0, `ERR`=0, `PERIODS`=0.
- Nominal run: `LIMIT`=2 with the real counter attached; pulse `START` while `Q`=10.
  - Required: `BUSY` high for 12 cycles, with `Q` sequence 10..15,10..15.
  - Required: `SLOAD` high in cycles 5 and 11, `PERIODS` reading 1 then 2.
  - Required: `DONE` high in cycle 12, then IDLE with `Q`=10.
- Start ignored: drive `Q`=7 and pulse `START` in IDLE.
  - Required: stays IDLE, `BUSY`=0, `SLOAD`=1.
  - Required: a later `START` with `Q`=10 is accepted.
- Mismatch: `LIMIT`=1; force `Q`=13 in the cycle where 12 is expected.
  - Required next cycle: `ERR`=1, `BUSY`=0, `SLOAD`=1, `PERIODS`=0, and `DONE` never pulses.
  - Required: the next accepted `START` clears `ERR`.
- LIMIT=0: required 96 `BUSY` cycles and `PERIODS` wrapping 15→0 on the final window, then `DONE` for 1 cycle.
- Reset mid-run: assert `R` in the cycle where `Q`=13 during window 1 of a `LIMIT`=3 run.
  - Required: `SLOAD`=1 in that cycle, next cycle IDLE with `Q`=10, `DONE`=0, `ERR`=0.
